// File: rtl/timing_pkg.sv
// timing_pkg
//   Shared definitions for the video timing generator: the per-axis phase
//   encoding, the 640x480@60 default segment lengths and the phase
//   successor function used by axis_timer.
package timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // 640x480 defaults (pixels / lines)
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_WIDTH    = 10;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_ACTIVE: n = PH_FRONT;
            PH_FRONT:  n = PH_SYNC;
            PH_SYNC:   n = PH_BACK;
            default:   n = PH_ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/timing_gen_axis_timer.sv
// axis_timer
//   One axis (horizontal or vertical) of the timing generator. Keeps a
//   position counter over the whole axis period plus a segment counter and
//   phase register that walk ACTIVE -> FRONT -> SYNC -> BACK.
// Ports
//   clk   in   clock
//   rst   in   synchronous active-high reset (count 0, phase ACTIVE)
//   step  in   advance by one position on this edge
//   count out  WIDTH  position within the axis period
//   phase out  current segment
//   wrap  out  count is at the last position (TOTAL-1); not gated by step
module axis_timer
    import timing_pkg::*;
#(
    parameter int unsigned SEG_ACTIVE = 640,
    parameter int unsigned SEG_FP     = 16,
    parameter int unsigned SEG_SYNC   = 96,
    parameter int unsigned SEG_BP     = 48,
    parameter int unsigned WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] count,
    output phase_e           phase,
    output logic             wrap
);

    localparam int unsigned TOTAL = SEG_ACTIVE + SEG_FP + SEG_SYNC + SEG_BP;

    if (SEG_ACTIVE == 0 || SEG_FP == 0 || SEG_SYNC == 0 || SEG_BP == 0) begin : g_bad_seg
        $error("axis_timer: every segment length must be nonzero");
    end
    if (((64'(TOTAL) - 64'd1) >> WIDTH) != 64'd0) begin : g_bad_width
        $error("axis_timer: TOTAL-1 does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] A_LAST   = WIDTH'(SEG_ACTIVE - 1);
    localparam logic [WIDTH-1:0] F_LAST   = WIDTH'(SEG_FP - 1);
    localparam logic [WIDTH-1:0] S_LAST   = WIDTH'(SEG_SYNC - 1);
    localparam logic [WIDTH-1:0] B_LAST   = WIDTH'(SEG_BP - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] seg_q, seg_d;
    logic [WIDTH-1:0] seg_last;
    phase_e           phase_q, phase_d;

    always_comb begin
        case (phase_q)
            PH_ACTIVE: seg_last = A_LAST;
            PH_FRONT:  seg_last = F_LAST;
            PH_SYNC:   seg_last = S_LAST;
            default:   seg_last = B_LAST;
        endcase
    end

    always_comb begin
        count_d = count_q;
        seg_d   = seg_q;
        phase_d = phase_q;
        if (step) begin
            count_d = (count_q == LAST_CNT) ? '0 : count_q + 1'b1;
            if (seg_q == seg_last) begin
                seg_d   = '0;
                phase_d = next_phase(phase_q);
            end else begin
                seg_d = seg_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            seg_q   <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            seg_q   <= seg_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;
    assign wrap  = (count_q == LAST_CNT);

endmodule

// File: rtl/timing_gen.sv
// timing_gen
//   Raster timing generator: a horizontal axis_timer stepped by the pixel
//   enable and a vertical axis_timer stepped once per line. Sync/active are
//   decoded from the registered phases, so they line up with hcount/vcount.
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset, overrides en
//   en           in   pixel enable
//   hcount       out  WIDTH  pixel position within the line
//   vcount       out  WIDTH  line position within the frame
//   hsync/vsync  out  H_POL/V_POL level while the axis is in its sync segment
//   active       out  both axes in their active segment
//   line_start   out  en at hcount==0
//   frame_start  out  en at hcount==0, vcount==0
module timing_gen
    import timing_pkg::*;
#(
    parameter int unsigned WIDTH    = VGA_WIDTH,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] hcount,
    output logic [WIDTH-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
);

    phase_e h_phase, v_phase;
    logic   h_wrap;
    logic   v_wrap_unused;  // frame wrap needs no top-level action

    axis_timer #(
        .SEG_ACTIVE (H_ACTIVE),
        .SEG_FP     (H_FP),
        .SEG_SYNC   (H_SYNC),
        .SEG_BP     (H_BP),
        .WIDTH      (WIDTH)
    ) u_h (
        .clk   (clk),
        .rst   (rst),
        .step  (en),
        .count (hcount),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // Vertical axis moves only on the enabled end-of-line edge, so its phase
    // can never change mid-line and both counters wrap on the same edge.
    axis_timer #(
        .SEG_ACTIVE (V_ACTIVE),
        .SEG_FP     (V_FP),
        .SEG_SYNC   (V_SYNC),
        .SEG_BP     (V_BP),
        .WIDTH      (WIDTH)
    ) u_v (
        .clk   (clk),
        .rst   (rst),
        .step  (h_wrap & en),
        .count (vcount),
        .phase (v_phase),
        .wrap  (v_wrap_unused)
    );

    assign hsync       = (h_phase == PH_SYNC) ? H_POL : ~H_POL;
    assign vsync       = (v_phase == PH_SYNC) ? V_POL : ~V_POL;
    assign active      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign line_start  = en && (hcount == '0);
    assign frame_start = en && (hcount == '0) && (vcount == '0);

endmodule

// File: tb/tb_timing_gen.sv
// Bench for timing_gen: two instances (tiny 8x5 raster with positive sync,
// and the 640x480 defaults) share one randomized en/rst stream and are
// compared each cycle against a position-based reference model.
module tb_timing_gen;

    logic clk = 1'b0;
    logic rst, en;
    always #5 clk = ~clk;

    // small instance: H 4/1/2/1, V 2/1/1/1, positive polarities
    logic [2:0] s_hc, s_vc;
    logic       s_hs, s_vs, s_ac, s_ls, s_fs;
    // default instance
    logic [9:0] d_hc, d_vc;
    logic       d_hs, d_vs, d_ac, d_ls, d_fs;

    timing_gen #(
        .WIDTH(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst), .en(en), .hcount(s_hc), .vcount(s_vc),
        .hsync(s_hs), .vsync(s_vs), .active(s_ac), .line_start(s_ls), .frame_start(s_fs)
    );

    timing_gen u_dflt (
        .clk(clk), .rst(rst), .en(en), .hcount(d_hc), .vcount(d_vc),
        .hsync(d_hs), .vsync(d_vs), .active(d_ac), .line_start(d_ls), .frame_start(d_fs)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs depend only on the position and the segment lengths.
    task automatic check_dut(input string p, input int hc, input int vc,
                             input logic hs, input logic vs, input logic ac,
                             input logic ls, input logic fs,
                             input int mh, input int mv,
                             input int ha, input int hf, input int hy,
                             input int va, input int vf, input int vy,
                             input bit hp, input bit vp);
        bit in_hs, in_vs;
        in_hs = (mh >= ha + hf) && (mh < ha + hf + hy);
        in_vs = (mv >= va + vf) && (mv < va + vf + vy);
        chk({p, ".hcount"}, hc, mh);
        chk({p, ".vcount"}, vc, mv);
        chk({p, ".hsync"}, int'(hs), in_hs ? int'(hp) : int'(!hp));
        chk({p, ".vsync"}, int'(vs), in_vs ? int'(vp) : int'(!vp));
        chk({p, ".active"}, int'(ac), int'(mh < ha && mv < va));
        chk({p, ".line_start"}, int'(ls), int'(en && mh == 0));
        chk({p, ".frame_start"}, int'(fs), int'(en && mh == 0 && mv == 0));
    endtask

    // reference positions
    int sh = 0, sv = 0, dh = 0, dv = 0;
    localparam int S_HT = 8, S_VT = 5, D_HT = 800, D_VT = 525;

    task automatic step_pos(inout int h, inout int v, input int ht, input int vt);
        if (rst) begin
            h = 0; v = 0;
        end else if (en) begin
            if (h == ht - 1) begin
                h = 0;
                v = (v == vt - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
        end
    endtask

    initial begin
        int sfs_last;
        rst = 1'b1;
        en  = 1'b0;
        sfs_last = -1;
        for (int cyc = 0; cyc < 4200; cyc++) begin
            @(negedge clk);
            if (cyc < 2)              begin rst = 1'b1; en = 1'($urandom_range(0, 1)); end
            else if (cyc < 2000)      begin rst = ($urandom_range(0, 299) == 0); en = ($urandom_range(0, 3) != 0); end
            else if (cyc < 2050)      begin rst = 1'b0; en = 1'b0; end          // long stall
            else if (cyc < 2950)      begin rst = 1'b0; en = ~en; end           // en toggling
            else                      begin rst = (cyc == 3500); en = 1'b1; end // free run
            #1;
            if (cyc > 0) begin
                check_dut("small", int'(s_hc), int'(s_vc), s_hs, s_vs, s_ac, s_ls, s_fs,
                          sh, sv, 4, 1, 2, 2, 1, 1, 1'b1, 1'b1);
                check_dut("dflt", int'(d_hc), int'(d_vc), d_hs, d_vs, d_ac, d_ls, d_fs,
                          dh, dv, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
                // with en held high the tiny raster repeats every 40 cycles
                if (cyc > 3510 && s_fs) begin
                    if (sfs_last >= 0) chk("small.frame_period", cyc - sfs_last, S_HT * S_VT);
                    sfs_last = cyc;
                end
            end
            @(posedge clk);
            step_pos(sh, sv, S_HT, S_VT);
            step_pos(dh, dv, D_HT, D_VT);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 10, bit width of both position counters.
REQ-002 SHALL have parameters H_ACTIVE, H_FP, H_SYNC, H_BP, defaults 640, 16, 96, 48, horizontal segment lengths in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, vertical segment lengths in lines.
REQ-004 SHALL have parameters H_POL, V_POL, default 0, sync asserted level (0 = active-low).
REQ-005 SHALL use a single clock and a synchronous active-high reset, in port order: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  pixel enable; all counters advance only on clk edges with en=1.
REQ-007 hcount  out  WIDTH  current pixel position within the line.
REQ-008 vcount  out  WIDTH  current line position within the frame.
REQ-009 hsync  out  1  horizontal sync at H_POL level during the sync segment.
REQ-010 vsync  out  1  vertical sync at V_POL level during the sync segment.
REQ-011 active  out  1  high when both axes are in their active segment.
REQ-012 line_start  out  1  single-cycle pulse: hcount==0 and en=1.
REQ-013 frame_start  out  1  single-cycle pulse: hcount==0, vcount==0 and en=1.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way; all arithmetic SHALL be unsigned.
REQ-015 Elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^WIDTH-1, or if any segment length is 0.
REQ-016 Each axis SHALL run the state machine ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, advancing when its segment counter reaches segment length-1.
REQ-017 hcount SHALL increment by 1 on each enabled edge and wrap from H_TOTAL-1 to 0.
REQ-018 vcount SHALL increment by 1 only on enabled edges where hcount==H_TOTAL-1, and wrap from V_TOTAL-1 to 0.
REQ-019 Segment ordering in count space: ACTIVE [0, ACTIVE-1], FRONT [ACTIVE, ACTIVE+FP-1], SYNC [ACTIVE+FP, ACTIVE+FP+SYNC-1], BACK to TOTAL-1.
REQ-020 hsync, vsync and active SHALL be decoded from the registered axis state; they SHALL have zero latency relative to hcount/vcount, i.e. valid in the same cycle.
REQ-021 With en=0, all registers SHALL hold; line_start and frame_start SHALL be 0.
REQ-022 When simultaneous h-wrap and v-wrap occur, both counters SHALL reach 0 on the same edge.
REQ-023 The vertical state SHALL change only on an h-wrap edge, never mid-line.

Reset
REQ-024 With rst=1 on a clk edge: hcount=0, vcount=0, both states ACTIVE; rst SHALL override en.
REQ-025 The values that follow directly from reset are: hsync=!H_POL, vsync=!V_POL, active=1; line_start and frame_start follow en.
REQ-026 Reset asserted mid-frame SHALL restart the frame at (0,0) on the next edge, with no partial sync pulse retained.

Structure
REQ-027 Package timing_pkg SHALL hold the phase enum (ACTIVE, FRONT, SYNC, BACK) and the 640x480 default constants.
REQ-028 Sub-module axis_timer (parameters: segment lengths, WIDTH; ports: clk, rst, step, count, phase, wrap) SHALL be instantiated twice.
REQ-029 The vertical axis_timer step SHALL be horizontal wrap AND en.

Verification
REQ-030 Defaults, en toggling every cycle -> hsync low exactly for hcount 656..751; line equals 1600 clk cycles.
REQ-031 Defaults, en=1 -> vsync low for vcount 490..491; frame_start period 420000 clk cycles; active high for 307200 cycles per frame.
REQ-032 Parameters H 4/1/2/1, V 2/1/1/1, H_POL=V_POL=1 -> hsync high at hcount 5..6, vsync high at vcount 3, wrap (7,4) -> (0,0) on the same edge.
REQ-033 rst pulsed at hcount=700, vcount=491 -> next cycle shows (0,0), hsync=vsync=1, frame_start=1 if en=1.
REQ-034 en held 0 for 50 cycles mid-sync -> counters and hsync frozen, no pulses; resumes with identical sequence.
